// File: rtl/expr_gen.sv
// expr_gen: pseudo-random ASCII expression generator, stream form
// "digit (op digit)*" with operators '+' and '*', one character per
// out_valid/out_ready handshake. Optional single-character corruption lets
// a downstream recognizer's reject path be exercised.
//
// Ports:
//   clk        system clock, rising edge
//   clr        asynchronous active-low reset
//   start      pulse; begins a new expression when idle
//   num_ops    operand count N (clamped to MAX_OPS; 0 ignores start)
//   seed       LFSR seed, latched on accepted start (0 behaves as 8'h01)
//   err_en     enable single-character corruption, latched on start
//   err_pos    character index to corrupt, latched on start
//   out_char   ASCII character
//   out_valid  out_char is valid
//   out_ready  downstream accepts out_char
//   busy       expression in progress
//   done       one-cycle pulse after the last character is accepted
//   char_cnt   index of the character currently presented
module expr_gen #(
  parameter int unsigned MAX_OPS = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [3:0] num_ops,
  input  logic [7:0] seed,
  input  logic       err_en,
  input  logic [3:0] err_pos,
  output logic [7:0] out_char,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic [3:0] char_cnt
);

  localparam logic [3:0] MAX_N = 4'(MAX_OPS);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_e;

  state_e      state_q;
  logic [3:0]  n_q;
  logic        err_en_q;
  logic [3:0]  err_pos_q;
  logic [7:0]  lfsr_q;
  logic [3:0]  cnt_q;
  logic [7:0]  char_q;
  logic        valid_q;
  logic        busy_q;
  logic        done_q;

  logic [3:0]  n_d;
  logic [7:0]  seed_d;
  logic [7:0]  first_char_d;
  logic [7:0]  lfsr_d;
  logic [3:0]  cnt_d;
  logic [7:0]  char_d;
  logic [4:0]  last_idx;
  logic        is_last;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Even index -> digit from lfsr[3:0] folded into 0..9, odd -> operator.
  // A corrupted slot gets a character of the wrong class.
  function automatic logic [7:0] sel_char(input logic [7:0] l,
                                          input logic [3:0] idx,
                                          input logic       corrupt);
    logic [7:0] c;
    if (!idx[0]) begin
      if (corrupt)
        c = 8'h2B;
      else if (l[3:0] < 4'd10)
        c = 8'h30 + {4'h0, l[3:0]};
      else
        c = 8'h30 + {4'h0, l[3:0] - 4'd10};
    end else begin
      if (corrupt)
        c = 8'h37;
      else
        c = l[0] ? 8'h2A : 8'h2B;
    end
    return c;
  endfunction

  always_comb begin
    n_d          = (num_ops > MAX_N) ? MAX_N : num_ops;
    seed_d       = (seed == 8'h00) ? 8'h01 : seed;
    first_char_d = sel_char(seed_d, 4'd0, err_en && (err_pos == 4'd0));
    lfsr_d       = lfsr_step(lfsr_q);
    cnt_d        = cnt_q + 4'd1;
    char_d       = sel_char(lfsr_d, cnt_d, err_en_q && (err_pos_q == cnt_d));
    last_idx     = {n_q, 1'b0} - 5'd2;
    is_last      = ({1'b0, cnt_q} == last_idx);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= IDLE;
      n_q       <= '0;
      err_en_q  <= 1'b0;
      err_pos_q <= '0;
      lfsr_q    <= 8'h01;
      cnt_q     <= '0;
      char_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start && (num_ops != 4'd0)) begin
            n_q       <= n_d;
            err_en_q  <= err_en;
            err_pos_q <= err_pos;
            lfsr_q    <= seed_d;
            cnt_q     <= '0;
            char_q    <= first_char_d;
            valid_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (is_last) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q  <= cnt_d;
              lfsr_q <= lfsr_d;
              char_q <= char_d;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_char  = char_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign char_cnt  = cnt_q;

endmodule
